// File: rtl/bk_add_stage.sv
// bk_add_stage: two-stage operand/result pipeline around an external 12-bit
// Brent-Kung adder, with accumulate mode and a saturating overflow counter.
module bk_add_stage #(
  parameter int OVF_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_a,
  input  logic [11:0]      in_b,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic [23:0]      add_in,
  input  logic [12:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [12:0]      out_sum,
  output logic             out_acc,
  output logic [11:0]      acc_val,
  output logic [OVF_W-1:0] ovf_cnt
);
  logic [11:0] op_a, op_b;
  logic s1_acc, s1_valid, s2_free, s1_adv, xfer;
  assign s2_free = ~out_valid | out_ready;
  assign s1_adv = s1_valid & s2_free;
  // accumulate ops wait for an empty S1 so acc_val already holds the prior result
  assign in_ready = rst_n & (~s1_valid | s1_adv) & ~(in_acc & s1_valid);
  assign xfer = in_valid & in_ready;
  for (genvar i = 0; i < 12; i++) begin : g_il
    assign add_in[2*i] = op_a[i];
    assign add_in[2*i+1] = op_b[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      s1_acc <= 1'b0;
      s1_valid <= 1'b0;
      out_sum <= '0;
      out_acc <= 1'b0;
      out_valid <= 1'b0;
      acc_val <= '0;
      ovf_cnt <= '0;
    end else begin
      if (xfer) begin
        op_a <= in_a;
        op_b <= in_acc ? acc_val : in_b;
        s1_acc <= in_acc;
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        out_sum <= add_sum;
        out_acc <= s1_acc;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc_clr) begin
        acc_val <= '0;
        ovf_cnt <= '0;
      end else if (s1_adv) begin
        acc_val <= add_sum[11:0];
        if (s1_acc && add_sum[12] && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bk_add_stage.sv
// tb_bk_add_stage: directed vectors against a queue-based scoreboard model,
// with a behavioural adder closing the add_in/add_sum loop.
module tb_bk_add_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_acc = 1'b0, acc_clr = 1'b0, out_ready = 1'b0;
  logic [11:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_acc;
  logic [23:0] add_in;
  logic [12:0] add_sum, out_sum;
  logic [11:0] acc_val;
  logic [7:0] ovf_cnt;
  int tests = 0, fails = 0;
  logic [13:0] q[$];
  logic [11:0] m_acc = '0;
  int m_ovf = 0;
  logic [12:0] last_sum = '0;

  bk_add_stage #(.OVF_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clr(acc_clr),
    .add_in(add_in), .add_sum(add_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_acc(out_acc),
    .acc_val(acc_val), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // adder model: de-interleave the bus and add as plain integers
  logic [11:0] ma, mb;
  always_comb begin
    ma = '0;
    mb = '0;
    for (int i = 0; i < 12; i++) begin
      ma[i] = add_in[2*i];
      mb[i] = add_in[2*i+1];
    end
    add_sum = {1'b0, ma} + {1'b0, mb};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: every accepted pair yields exactly one result, in order
  always @(negedge clk) if (rst_n) begin
    logic [11:0] b;
    logic [12:0] s;
    logic [13:0] e;
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out", 0, 1);
      else if (out_ready) begin
        e = q.pop_front();
        chk("out_sum", {19'd0, out_sum}, {19'd0, e[12:0]});
        chk("out_acc", {31'd0, out_acc}, {31'd0, e[13]});
        last_sum = out_sum;
      end
    end
    if (in_valid && in_ready) begin
      b = in_acc ? m_acc : in_b;
      s = {1'b0, in_a} + {1'b0, b};
      q.push_back({in_acc, s});
      m_acc = s[11:0];
      if (in_acc && s[12] && m_ovf < 255) m_ovf++;
    end
    if (acc_clr) begin
      m_acc = '0;
      m_ovf = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [11:0] a, input logic [11:0] b, input logic acc);
    logic got;
    in_a = a;
    in_b = b;
    in_acc = acc;
    in_valid = 1'b1;
    #1;
    for (int c = 0; c < 50; c++) begin
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) return;
    end
    chk("accept_timeout", 0, 1);
  endtask

  logic [11:0] sa[4] = '{12'h001, 12'h003, 12'h800, 12'hABC};
  logic [11:0] sb[4] = '{12'h002, 12'h004, 12'h800, 12'h123};
  logic [12:0] se[4] = '{13'h0003, 13'h0007, 13'h1000, 13'h0BDF};
  logic [11:0] ba[3] = '{12'h010, 12'h020, 12'h030};
  logic [11:0] bb[3] = '{12'h00F, 12'h0FF, 12'hFFF};

  initial begin
    int idx;
    logic got;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_add_in", {8'd0, add_in}, 0);
    chk("rst_out_sum", {19'd0, out_sum}, 0);
    chk("rst_acc_val", {20'd0, acc_val}, 0);
    chk("rst_ovf", {24'd0, ovf_cnt}, 0);
    tick;
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    // first transaction and latency
    offer(12'hFFF, 12'h001, 1'b0);
    in_valid = 1'b0;
    chk("lat_add_in", {8'd0, add_in}, 32'h555557);
    chk("lat_out_valid_early", {31'd0, out_valid}, 0);
    tick;
    chk("lat_out_valid", {31'd0, out_valid}, 1);
    chk("lat_out_sum", {19'd0, out_sum}, 32'h1000);
    chk("lat_out_acc", {31'd0, out_acc}, 0);
    tick;
    chk("lat_acc_val", {20'd0, acc_val}, 0);
    chk("lat_ovf", {24'd0, ovf_cnt}, 0);
    // streaming
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        in_a = sa[k];
        in_b = sb[k];
        in_acc = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("stream_in_ready", {31'd0, in_ready}, 1);
      end else in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (k > 0) begin
        chk("stream_valid", {31'd0, out_valid}, 1);
        chk("stream_sum", {19'd0, out_sum}, {19'd0, se[k-1]});
      end
    end
    tick;
    // backpressure
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_a = ba[idx];
      in_b = bb[idx];
      in_valid = 1'b1;
      #1;
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_held_sum", {19'd0, out_sum}, 32'h001F);
    out_ready = 1'b1;
    offer(ba[2], bb[2], 1'b0);
    in_valid = 1'b0;
    repeat (4) tick;
    chk("bp_drained", q.size(), 0);
    chk("bp_last_sum", {19'd0, last_sum}, 32'h102F);
    // accumulate
    acc_clr = 1'b1;
    tick;
    acc_clr = 1'b0;
    chk("clr_acc_val", {20'd0, acc_val}, 0);
    for (int n = 0; n < 3; n++) begin
      offer(12'h900, 12'h000, 1'b1);
      chk("acc_hazard_ready", {31'd0, in_ready}, 0);
    end
    in_valid = 1'b0;
    in_acc = 1'b0;
    repeat (3) tick;
    chk("acc_last_sum", {19'd0, last_sum}, 32'h0B00);
    chk("acc_val_lit", {20'd0, acc_val}, 32'hB00);
    chk("acc_val_model", {20'd0, acc_val}, {20'd0, m_acc});
    chk("acc_ovf", {24'd0, ovf_cnt}, 1);
    chk("acc_drained", q.size(), 0);
    // saturation
    acc_clr = 1'b1;
    tick;
    acc_clr = 1'b0;
    offer(12'hFFF, 12'h000, 1'b0);
    in_valid = 1'b0;
    repeat (3) tick;
    chk("sat_seed", {20'd0, acc_val}, 32'hFFF);
    for (int n = 0; n < 300; n++) offer(12'hFFF, 12'h000, 1'b1);
    in_valid = 1'b0;
    in_acc = 1'b0;
    repeat (3) tick;
    chk("sat_ovf", {24'd0, ovf_cnt}, 255);
    chk("sat_ovf_model", {24'd0, ovf_cnt}, m_ovf);
    chk("sat_acc_val", {20'd0, acc_val}, {20'd0, m_acc});
    acc_clr = 1'b1;
    tick;
    acc_clr = 1'b0;
    chk("sat_clr_acc", {20'd0, acc_val}, 0);
    chk("sat_clr_ovf", {24'd0, ovf_cnt}, 0);
    // async reset with both stages full
    out_ready = 1'b0;
    offer(12'h111, 12'h222, 1'b0);
    offer(12'h333, 12'h444, 1'b0);
    chk("full_out_valid", {31'd0, out_valid}, 1);
    #2;
    rst_n = 1'b0;
    q.delete();
    m_acc = '0;
    m_ovf = 0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_in_ready", {31'd0, in_ready}, 0);
    chk("arst_add_in", {8'd0, add_in}, 0);
    in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick;
    chk("post_rst_idle", {31'd0, out_valid}, 0);
    offer(12'h123, 12'h456, 1'b0);
    in_valid = 1'b0;
    tick;
    chk("post_rst_valid", {31'd0, out_valid}, 1);
    chk("post_rst_sum", {19'd0, out_sum}, 32'h0579);
    repeat (2) tick;
    chk("post_rst_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
